// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 bus responder: DDRAM geometry,
// FSM encoding, instruction decode and address-counter arithmetic.
package lcd_pkg;

  localparam logic [6:0] ROW0_BASE = 7'h00;
  localparam logic [6:0] ROW1_BASE = 7'h40;
  localparam int         ROW_LEN   = 40;
  localparam logic [7:0] SPACE     = 8'h20;

  // Last valid address of each row; the AC wraps between these.
  localparam logic [6:0] ROW0_LAST = ROW0_BASE + 7'(ROW_LEN - 1);
  localparam logic [6:0] ROW1_LAST = ROW1_BASE + 7'(ROW_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CLEAR, S_BUSY} state_t;

  typedef enum logic [3:0] {
    I_NOP, I_CLEAR, I_HOME, I_ENTRY, I_DISP, I_SHIFT, I_FUNC, I_CGRAM, I_DDRAM
  } instr_t;

  // Instruction class is chosen by the highest set bit of the opcode.
  function automatic instr_t decode(input logic [7:0] d);
    casez (d)
      8'b1???_????: return I_DDRAM;
      8'b01??_????: return I_CGRAM;
      8'b001?_????: return I_FUNC;
      8'b0001_????: return I_SHIFT;
      8'b0000_1???: return I_DISP;
      8'b0000_01??: return I_ENTRY;
      8'b0000_001?: return I_HOME;
      8'b0000_0001: return I_CLEAR;
      default:      return I_NOP;
    endcase
  endfunction

  // Step the AC by one across the two 40-byte rows, wrapping row to row.
  function automatic logic [6:0] ac_next(input logic [6:0] ac, input logic inc);
    if (inc) begin
      if (ac == ROW0_LAST) return ROW1_BASE;
      if (ac == ROW1_LAST) return ROW0_BASE;
      return ac + 7'd1;
    end
    if (ac == ROW0_BASE) return ROW1_LAST;
    if (ac == ROW1_BASE) return ROW0_LAST;
    return ac - 7'd1;
  endfunction

  // Set-DDRAM-address: addresses past the end of a row snap to that row's start.
  function automatic logic [6:0] ddram_addr(input logic [6:0] a);
    if (a[5:0] >= 6'(ROW_LEN)) return a[6] ? ROW1_BASE : ROW0_BASE;
    return a;
  endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 80-byte display data RAM addressed in AC space (row 0 at 0x00, row 1 at 0x40).
// One synchronous write port, two combinational read ports.
module lcd_ddram import lcd_pkg::*; (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [6:0] waddr,
  input  logic [7:0] wdata,
  input  logic [6:0] raddr_a,
  output logic [7:0] rdata_a,
  input  logic [6:0] raddr_b,
  output logic [7:0] rdata_b
);

  localparam int DEPTH = 2 * ROW_LEN;

  logic [DEPTH-1:0][7:0] mem;

  // Row 1 lives directly after row 0 in the physical array.
  function automatic logic [6:0] idx(input logic [6:0] a);
    return a[6] ? 7'(ROW_LEN) + {1'b0, a[5:0]} : {1'b0, a[5:0]};
  endfunction

  assign rdata_a = mem[idx(raddr_a)];
  assign rdata_b = mem[idx(raddr_b)];

  // Single write port; the array powers up blank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem <= {DEPTH{SPACE}};
    else if (we) mem[idx(waddr)] <= wdata;
  end

endmodule

// File: rtl/lcd_hd44780_responder.sv
// Bus-side HD44780 16x2 model: synchronises the controller's strobe, decodes
// 8-bit instructions, keeps DDRAM/AC/flags and answers status and data reads.
module lcd_hd44780_responder import lcd_pkg::*; #(
  parameter int BUSY_CYCLES  = 2000,
  parameter int CLEAR_CYCLES = 82000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rs,
  input  logic       rw,
  input  logic       ena,
  input  logic [7:0] dat_in,
  output logic [7:0] dat_out,
  output logic       dat_oe,
  output logic       busy,
  output logic       overrun,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic [6:0] ac_out,
  input  logic       disp_row,
  input  logic [3:0] disp_col,
  output logic [7:0] disp_char
);

  localparam int MAXC = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  logic       ena_s1, ena_s2, ena_d;
  logic       rs_s1, rs_s2, rs_d;
  logic       rw_s1, rw_s2, rw_d;
  logic [7:0] dat_s1, dat_s2, dat_d;
  logic       rise, fall;

  state_t        state;
  logic [CW-1:0] cnt, w_len;
  logic          cmd_rs;
  logic [7:0]    cmd_dat;
  logic [6:0]    ac, clr_addr;
  logic          id;

  logic       we;
  logic [6:0] waddr;
  logic [7:0] wdata, bus_rd, disp_rd;

  assign rise   = ena_s2 & ~ena_d;
  assign fall   = ~ena_s2 & ena_d;
  assign ac_out = ac;

  // Clear and return-home hold busy for the long period, everything else the short one.
  assign w_len = (!rs_d && (decode(dat_d) == I_CLEAR || decode(dat_d) == I_HOME))
               ? CW'(CLEAR_CYCLES - 1) : CW'(BUSY_CYCLES - 1);

  lcd_ddram u_ddram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (ac),
    .rdata_a (bus_rd),
    .raddr_b ({disp_row, 2'b00, disp_col}),
    .rdata_b (disp_rd)
  );

  // 2-flop strobe synchroniser; bus fields ride the same pipe so they stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {ena_s1, ena_s2, ena_d} <= '0;
      {rs_s1, rs_s2, rs_d}    <= '0;
      {rw_s1, rw_s2, rw_d}    <= '0;
      {dat_s1, dat_s2, dat_d} <= '0;
    end else begin
      {ena_s1, ena_s2, ena_d} <= {ena, ena_s1, ena_s2};
      {rs_s1, rs_s2, rs_d}    <= {rs, rs_s1, rs_s2};
      {rw_s1, rw_s2, rw_d}    <= {rw, rw_s1, rw_s2};
      {dat_s1, dat_s2, dat_d} <= {dat_in, dat_s1, dat_s2};
    end
  end

  // DDRAM write source: data write during EXEC, or the blanking sweep.
  always_comb begin
    we    = 1'b0;
    waddr = ac;
    wdata = cmd_dat;
    if (state == S_EXEC && cmd_rs) we = 1'b1;
    if (state == S_CLEAR) begin
      we    = 1'b1;
      waddr = clr_addr;
      wdata = SPACE;
    end
  end

  // Display mirror port, one cycle of latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) disp_char <= '0;
    else        disp_char <= disp_rd;
  end

  // Bus reads, overrun detection and the instruction FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      dat_out    <= '0;
      dat_oe     <= 1'b0;
      cmd_rs     <= 1'b0;
      cmd_dat    <= '0;
      ac         <= ROW0_BASE;
      clr_addr   <= ROW0_BASE;
      id         <= 1'b1;
      display_on <= 1'b0;
      cursor_on  <= 1'b0;
      blink_on   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (cnt != '0) cnt <= cnt - CW'(1);

      // Reads bypass the busy flag entirely.
      if (rise && rw_s2) begin
        dat_oe  <= 1'b1;
        dat_out <= rs_s2 ? bus_rd : {busy, ac};
      end
      if (fall && rw_d) begin
        dat_oe <= 1'b0;
        if (rs_d) ac <= ac_next(ac, id);
      end
      if (fall && !rw_d && busy) overrun <= 1'b1;

      case (state)
        S_IDLE: if (fall && !rw_d) begin
          state   <= S_EXEC;
          busy    <= 1'b1;
          cmd_rs  <= rs_d;
          cmd_dat <= dat_d;
          cnt     <= w_len;
        end
        S_EXEC: begin
          state <= S_BUSY;
          if (cmd_rs) ac <= ac_next(ac, id);
          else begin
            case (decode(cmd_dat))
              I_DDRAM: ac <= ddram_addr(cmd_dat[6:0]);
              I_SHIFT: if (!cmd_dat[3]) ac <= ac_next(ac, cmd_dat[2]);
              I_DISP:  {display_on, cursor_on, blink_on} <= cmd_dat[2:0];
              // The shift bit only steers display shift, which this model does not render.
              I_ENTRY: id <= cmd_dat[1];
              I_HOME:  ac <= ROW0_BASE;
              I_CLEAR: begin
                ac       <= ROW0_BASE;
                id       <= 1'b1;
                clr_addr <= ROW0_BASE;
                state    <= S_CLEAR;
              end
              default: ;
            endcase
          end
        end
        S_CLEAR: begin
          if (clr_addr == ROW1_LAST) state <= S_BUSY;
          else clr_addr <= ac_next(clr_addr, 1'b1);
        end
        S_BUSY: if (cnt == '0) begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Randomised bench for lcd_hd44780_responder with a cycle-level behavioural model.
module tb_lcd_hd44780_responder;

  localparam int BC = 10;
  localparam int CC = 100;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       rs = 1'b0, rw = 1'b0, ena = 1'b0;
  logic [7:0] dat_in = '0;
  logic [7:0] dat_out, disp_char;
  logic       dat_oe, busy, overrun, display_on, cursor_on, blink_on;
  logic [6:0] ac_out;
  logic       disp_row = 1'b0;
  logic [3:0] disp_col = '0;

  int n_cmp = 0, n_bad = 0;

  lcd_hd44780_responder #(.BUSY_CYCLES(BC), .CLEAR_CYCLES(CC)) dut (
    .clk(clk), .rst_n(rst_n), .rs(rs), .rw(rw), .ena(ena), .dat_in(dat_in),
    .dat_out(dat_out), .dat_oe(dat_oe), .busy(busy), .overrun(overrun),
    .display_on(display_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .ac_out(ac_out), .disp_row(disp_row), .disp_col(disp_col), .disp_char(disp_char)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed { logic e; logic rs; logic rw; logic [7:0] d; } bus_t;

  logic [7:0] mm [0:127];
  logic [6:0] m_ac, pre_ac;
  logic       m_id, m_d, m_c, m_b, m_oe, m_ovr, pre_busy, m_pend, m_prs, rise_m, fall_m;
  logic [7:0] m_dout, m_disp, m_pdat;
  int         m_bl, m_clrw;
  bus_t       h [0:3];

  // AC moves over a linear 80-cell ring: 0..39 are row 0, 40..79 are row 1.
  function automatic logic [6:0] m_step(input logic [6:0] a, input logic inc);
    int l;
    l = (a >= 7'h40) ? int'(a) - 64 + 40 : int'(a);
    l = inc ? (l + 1) % 80 : (l + 79) % 80;
    return (l < 40) ? 7'(l) : 7'(l - 40 + 64);
  endfunction

  task automatic m_apply(input logic r_s, input logic [7:0] d);
    int a;
    if (r_s) begin
      mm[m_ac] = d;
      m_ac = m_step(m_ac, m_id);
    end else if (d >= 8'h80) begin
      a = int'(d[6:0]);
      if (a >= 'h28 && a < 'h40) a = 0;
      else if (a >= 'h68) a = 'h40;
      m_ac = 7'(a);
    end else if (d >= 8'h20) begin
      a = 0;
    end else if (d >= 8'h10) begin
      if (!d[3]) m_ac = m_step(m_ac, d[2]);
    end else if (d >= 8'h08) begin
      {m_d, m_c, m_b} = d[2:0];
    end else if (d >= 8'h04) begin
      m_id = d[1];
    end else if (d >= 8'h02) begin
      m_ac = 7'h00;
    end else if (d == 8'h01) begin
      for (int i = 0; i < 128; i++) mm[i] = 8'h20;
      m_ac = 7'h00;
      m_id = 1'b1;
      m_clrw = 82;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 128; i++) mm[i] = 8'h20;
      m_ac = '0; m_id = 1'b1; m_d = 0; m_c = 0; m_b = 0;
      m_oe = 0; m_ovr = 0; m_dout = '0; m_disp = '0;
      m_bl = 0; m_clrw = 0; m_pend = 0; m_prs = 0; m_pdat = '0;
      for (int i = 0; i < 4; i++) h[i] = '0;
    end else begin
      m_disp   = mm[{disp_row, 2'b00, disp_col}];
      pre_busy = (m_bl > 0);
      pre_ac   = m_ac;
      h[3] = h[2]; h[2] = h[1]; h[1] = h[0];
      h[0] = {ena, rs, rw, dat_in};
      rise_m = h[2].e & ~h[3].e;
      fall_m = ~h[2].e & h[3].e;
      m_ovr = 1'b0;
      if (m_bl > 0) m_bl--;
      if (m_clrw > 0) m_clrw--;
      if (rise_m && h[2].rw) begin
        m_oe = 1'b1;
        m_dout = h[2].rs ? mm[pre_ac] : {pre_busy, pre_ac};
      end
      if (m_pend) begin
        m_apply(m_prs, m_pdat);
        m_pend = 1'b0;
      end
      if (fall_m && h[3].rw) begin
        m_oe = 1'b0;
        if (h[3].rs) m_ac = m_step(m_ac, m_id);
      end
      if (fall_m && !h[3].rw) begin
        if (pre_busy) m_ovr = 1'b1;
        else begin
          m_pend = 1'b1;
          m_prs  = h[3].rs;
          m_pdat = h[3].d;
          m_bl   = (!h[3].rs && h[3].d >= 8'h01 && h[3].d <= 8'h03) ? CC : BC;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int cur_len = 0, last_len = 0, ov_cnt = 0;

  always @(negedge clk) begin
    check("busy",       32'(busy),       32'(m_bl > 0));
    check("overrun",    32'(overrun),    32'(m_ovr));
    check("ac_out",     32'(ac_out),     32'(m_ac));
    check("display_on", 32'(display_on), 32'(m_d));
    check("cursor_on",  32'(cursor_on),  32'(m_c));
    check("blink_on",   32'(blink_on),   32'(m_b));
    check("dat_oe",     32'(dat_oe),     32'(m_oe));
    check("dat_out",    32'(dat_out),    32'(m_dout));
    if (m_clrw == 0) check("disp_char", 32'(disp_char), 32'(m_disp));
    if (overrun === 1'b1) ov_cnt++;
    if (busy === 1'b1) cur_len++;
    else if (cur_len > 0) begin
      last_len = cur_len;
      cur_len = 0;
    end
  end

  // ---------------- stimulus ----------------
  bit rand_disp = 1'b1;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      if (rand_disp) begin
        disp_row = 1'($urandom);
        disp_col = 4'($urandom);
      end
    end
  endtask

  task automatic bus(input logic r_s, input logic r_w, input logic [7:0] d, input int w);
    rs = r_s; rw = r_w; dat_in = d;
    cyc(1); ena = 1'b1; cyc(w); ena = 1'b0; cyc(3);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 300) begin cyc(1); k++; end
    check("idle_timeout", 32'(busy), 32'(0));
  endtask

  task automatic wr(input logic r_s, input logic [7:0] d);
    bus(r_s, 1'b0, d, 4); wait_idle(); cyc(1);
  endtask

  task automatic rd(input logic r_s, output logic [7:0] v, output logic oe);
    rs = r_s; rw = 1'b1;
    cyc(1); ena = 1'b1; cyc(4);
    v = dat_out; oe = dat_oe;
    ena = 1'b0; cyc(3);
  endtask

  task automatic peek(input logic r, input logic [3:0] c, output logic [7:0] v);
    rand_disp = 1'b0; disp_row = r; disp_col = c;
    cyc(2); v = disp_char; rand_disp = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    logic [7:0] v;
    logic       oe;
    int         ov0;
    cyc(3); rst_n = 1'b1; cyc(2);
    check("rst_ac",   32'(ac_out),  32'h00);
    check("rst_busy", 32'(busy),    32'h0);
    check("rst_oe",   32'(dat_oe),  32'h0);
    check("rst_dout", 32'(dat_out), 32'h00);
    rd(1'b0, v, oe);
    check("status_after_reset", 32'(v), 32'h00);
    check("status_oe", 32'(oe), 32'h1);
    check("oe_after_fall", 32'(dat_oe), 32'h0);
    peek(1'b1, 4'd15, v);
    check("blank_1_15", 32'(v), 32'h20);

    wr(0, 8'h38); wr(0, 8'h0C); wr(0, 8'h06); wr(0, 8'h80); wr(1, 8'h48);
    check("ac_after_H", 32'(ac_out), 32'h01);
    check("display_on_lit", 32'(display_on), 32'h1);
    check("cursor_on_lit", 32'(cursor_on), 32'h0);
    check("busy_len_write", 32'(last_len), 32'(BC));
    peek(1'b0, 4'd0, v);
    check("char_0_0_H", 32'(v), 32'h48);

    wr(0, 8'hA7);
    check("ac_set_27", 32'(ac_out), 32'h27);
    wr(1, 8'h58);
    check("ac_wrap_40", 32'(ac_out), 32'h40);
    check("model_27", 32'(mm[7'h27]), 32'h58);
    wr(0, 8'hA7); rd(1'b1, v, oe);
    check("read_27", 32'(v), 32'h58);
    wr(0, 8'h04); wr(0, 8'h80); wr(1, 8'h5A);
    check("ac_dec_wrap_67", 32'(ac_out), 32'h67);

    wr(0, 8'h06); wr(0, 8'h80);
    ov0 = ov_cnt;
    bus(1'b1, 1'b0, 8'h41, 4);
    bus(1'b1, 1'b0, 8'h42, 4);
    wait_idle(); cyc(1);
    check("overrun_pulses", 32'(ov_cnt - ov0), 32'd1);
    check("ac_after_overrun", 32'(ac_out), 32'h01);
    peek(1'b0, 4'd0, v);
    check("char_0_0_A", 32'(v), 32'h41);
    peek(1'b0, 4'd1, v);
    check("char_0_1_dropped", 32'(v), 32'h20);

    wr(0, 8'hC0);
    for (int i = 0; i < 16; i++) wr(1, 8'(8'h61 + i));
    peek(1'b1, 4'd5, v);
    check("row1_fill", 32'(v), 32'h66);
    bus(1'b0, 1'b0, 8'h01, 4);
    rd(1'b0, v, oe);
    check("status_during_clear", 32'(v), 32'h80);
    wait_idle(); cyc(1);
    check("busy_len_clear", 32'(last_len), 32'(CC));
    check("ac_after_clear", 32'(ac_out), 32'h00);
    peek(1'b1, 4'd5, v);
    check("row1_cleared", 32'(v), 32'h20);

    wr(0, 8'hB0);
    check("ac_snap_row0", 32'(ac_out), 32'h00);
    wr(0, 8'hF5);
    check("ac_snap_row1", 32'(ac_out), 32'h40);
    wr(1, 8'h41); wr(0, 8'hC0);
    rd(1'b1, v, oe);
    check("read_data_40", 32'(v), 32'h41);
    check("ac_after_read", 32'(ac_out), 32'h41);

    bus(1'b0, 1'b0, 8'h00, 4);
    cyc(2);
    check("busy_before_rst", 32'(busy), 32'h1);
    rst_n = 1'b0; #1;
    check("busy_async_rst", 32'(busy), 32'h0);
    cyc(2); rst_n = 1'b1; cyc(2);

    for (int n = 0; n < 150; n++) begin
      logic [7:0] d;
      d = 8'($urandom);
      if (d >= 8'h01 && d <= 8'h03 && ($urandom % 4) != 0) d = d | 8'h80;
      bus(1'($urandom), 1'($urandom), d, 4 + int'($urandom % 3));
      cyc(int'($urandom % 12));
    end
    wait_idle(); cyc(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
